// File: rtl/tx_block_if.sv
// Host-side bundle for tx_block: byte load handshake, serial line and status flags.
// master = byte producer, slave = transmitter.
interface tx_block_if;
  logic [7:0] tx_data;
  logic       load_data;
  logic       serial_out;
  logic       buffer_full;
  logic       tx_busy;
  logic       overrun_error;

  modport master (
    output tx_data, load_data,
    input  serial_out, buffer_full, tx_busy, overrun_error
  );

  modport slave (
    input  tx_data, load_data,
    output serial_out, buffer_full, tx_busy, overrun_error
  );
endinterface

// File: rtl/tx_block.sv
// UART-style transmitter: start, 8 data bits LSB first, optional even parity (TX_PARITY_EN), stop.
// Latency: line falls one cycle after a byte is captured into an empty buffer; BIT_PERIOD cycles per bit.
// Backpressure: one-byte holding buffer; buffer_full blocks loads and a dropped load pulses overrun_error.
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic     clk,
  input  logic     n_rst,
  tx_block_if.slave bus
);

  localparam int             CW       = $clog2(BIT_PERIOD);
  localparam logic [CW-1:0]  CYC_LAST = CW'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [2:0]    bit_q;
  logic [7:0]    hold_q;
  logic          hold_vld_q;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          ovr_q;
`ifdef TX_PARITY_EN
  logic          par_q;
`endif

  logic bit_end;
  logic transfer;
  logic accept;

  assign bit_end  = (cyc_q == CYC_LAST);
  // Holding register drains into the shifter from IDLE or at the last cycle of a stop bit.
  assign transfer = hold_vld_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign accept   = bus.load_data && (!hold_vld_q || transfer);

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (hold_vld_q) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_q == 3'd7)) begin
`ifdef TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = hold_vld_q ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: next shifter contents and the line level registered for the next cycle
  always_comb begin
    shift_d = shift_q;
    if (transfer) begin
      shift_d = hold_q;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = {1'b0, shift_q[7:1]};
    end

    line_d = 1'b1;
    case (state_d)
      IDLE:   line_d = 1'b1;
      START:  line_d = 1'b0;
      DATA:   line_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY: line_d = par_q;
`endif
      STOP:   line_d = 1'b1;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc_q      <= '0;
      bit_q      <= 3'd0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      shift_q    <= 8'h00;
      line_q     <= 1'b1;
      ovr_q      <= 1'b0;
    end else begin
      shift_q <= shift_d;
      line_q  <= line_d;
      ovr_q   <= bus.load_data && !accept;

      if (state_q == IDLE) begin
        cyc_q <= '0;
      end else if (bit_end) begin
        cyc_q <= '0;
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end

      if ((state_q == START) && bit_end) begin
        bit_q <= 3'd0;
      end else if ((state_q == DATA) && bit_end) begin
        bit_q <= bit_q + 3'd1;
      end

      if (accept) begin
        hold_q     <= bus.tx_data;
        hold_vld_q <= 1'b1;
      end else if (transfer) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

`ifdef TX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q <= 1'b0;
    end else if (transfer) begin
      par_q <= ^hold_q;
    end
  end
`endif

  assign bus.serial_out    = line_q;
  assign bus.overrun_error = ovr_q;
  assign bus.buffer_full   = hold_vld_q;
  assign bus.tx_busy       = (state_q != IDLE) || hold_vld_q;

endmodule

// File: tb/tb_tx_block.sv
// Bench for tx_block: directed frames plus random loads, compared each cycle against a timeline model
// that tracks frame start times and the one-byte buffer.
module tb_tx_block;

  localparam int BP = 10;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BP;

  logic clk;
  logic n_rst;

  tx_block_if bus();

  tx_block #(.BIT_PERIOD(BP)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model: edge counter, in-flight frame (start edge + byte), holding buffer, overrun pulse.
  int         t;
  bit         m_active;
  int         m_start;
  logic [7:0] m_cur;
  bit         m_hv;
  logic [7:0] m_hold;
  bit         m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic exp_line();
    int idx;
    if (!m_active) return 1'b1;
    idx = (t - m_start) / BP;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
`ifdef TX_PARITY_EN
    if (idx == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  function automatic bit transfer_next();
    return m_hv && (!m_active || (t + 1 == m_start + FL));
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_start  = 0;
    m_cur    = 8'h00;
    m_hv     = 0;
    m_hold   = 8'h00;
    m_ovr    = 0;
  endtask

  task automatic model_edge(input bit ld, input logic [7:0] d);
    bit hv_before;
    bit xfer;
    bit acc;
    t++;
    hv_before = m_hv;
    xfer = 0;
    if (m_active && (t == m_start + FL)) m_active = 0;
    if (!m_active && m_hv) begin
      xfer     = 1;
      m_active = 1;
      m_start  = t;
      m_cur    = m_hold;
      m_hv     = 0;
    end
    acc = ld && (!hv_before || xfer);
    if (acc) begin
      m_hv   = 1;
      m_hold = d;
    end
    m_ovr = ld && !acc;
  endtask

  task automatic check_outputs();
    check("serial_out", 32'(bus.serial_out), 32'(exp_line()));
    check("buffer_full", 32'(bus.buffer_full), 32'(m_hv));
    check("tx_busy", 32'(bus.tx_busy), 32'(m_active || m_hv));
    check("overrun_error", 32'(bus.overrun_error), 32'(m_ovr));
  endtask

  // Called at a falling edge: drive, let one rising edge happen, check at the next falling edge.
  task automatic step(input bit ld, input logic [7:0] d);
    bus.load_data = ld;
    bus.tx_data   = d;
    @(posedge clk);
    model_edge(ld, d);
    @(negedge clk);
    bus.load_data = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    t = 0;
    model_reset();
    n_rst = 1'b0;
    bus.load_data = 1'b0;
    bus.tx_data   = 8'h00;

    repeat (3) @(negedge clk);
    check_outputs();
    n_rst = 1'b1;
    idle(3);

    // single byte, then the parity-sensitive one
    step(1'b1, 8'hA5);
    idle(FL + 10);
    step(1'b1, 8'h07);
    idle(FL + 10);

    // back-to-back 00 then FF
    step(1'b1, 8'h00);
    idle(20);
    step(1'b1, 8'hFF);
    idle(2 * FL + 10);

    // overrun: 33 must be dropped
    step(1'b1, 8'h11);
    idle(5);
    step(1'b1, 8'h22);
    idle(5);
    step(1'b1, 8'h33);
    idle(2 * FL + 10);

    // load landing on the exact transfer edge
    step(1'b1, 8'hC3);
    idle(3);
    step(1'b1, 8'h3C);
    begin
      int guard;
      guard = 0;
      while (!transfer_next() && guard < 4 * FL) begin
        step(1'b0, 8'h00);
        guard++;
      end
      check("xfer_wait_timeout", 32'(transfer_next()), 32'd1);
    end
    step(1'b1, 8'h5A);
    check("simul_accept_full", 32'(bus.buffer_full), 32'd1);
    check("simul_no_overrun", 32'(bus.overrun_error), 32'd0);
    idle(3 * FL + 10);

    // reset mid-frame
    step(1'b1, 8'h96);
    step(1'b1, 8'h69);
    idle(40);
    n_rst = 1'b0;
    #1;
    model_reset();
    check("rst_serial_out", 32'(bus.serial_out), 32'd1);
    check("rst_buffer_full", 32'(bus.buffer_full), 32'd0);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun_error), 32'd0);
    repeat (3) @(negedge clk);
    check_outputs();
    n_rst = 1'b1;
    idle(5);

    // random traffic with occasional bursts and quiet gaps
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      if ((i / 500) % 2 == 0) ld = ($urandom_range(0, 7) == 0);
      else                    ld = ($urandom_range(0, 60) == 0);
      step(ld, 8'($urandom));
    end
    idle(2 * FL + 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
